// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchronised per-bit switch debouncer; a level is accepted
// only after STABLE_TICKS consecutive prescaler ticks of mismatch, with edge pulses.
module sw_debounce #(
  parameter int WIDTH        = 16,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  logic [WIDTH-1:0]         r_s1, r_s2;
  logic [PW-1:0]            r_pre;
  logic [WIDTH-1:0][CW-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]         w_acc;
  logic                     w_tick;
  assign w_tick = r_pre == PW'(TICK_DIV - 1);
  // any cycle where s2 matches out discards the partial count, tick or not
  always_comb begin
    w_acc     = '0;
    w_cnt_nxt = r_cnt;
    for (int n = 0; n < WIDTH; n++) begin
      w_acc[n]     = w_tick && (r_s2[n] != out_o[n]) && (r_cnt[n] == CW'(STABLE_TICKS - 1));
      w_cnt_nxt[n] = (r_s2[n] == out_o[n] || w_acc[n]) ? '0 : w_tick ? r_cnt[n] + CW'(1) : r_cnt[n];
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_pre    <= '0;
      r_cnt    <= '0;
      out_o    <= '0;
      rise_o   <= '0;
      fall_o   <= '0;
      change_o <= 1'b0;
    end else begin
      r_s1     <= sw_i;
      r_s2     <= r_s1;
      r_pre    <= w_tick ? '0 : r_pre + PW'(1);
      r_cnt    <= w_cnt_nxt;
      out_o    <= out_o ^ w_acc;
      rise_o   <= w_acc & r_s2;
      fall_o   <= w_acc & ~r_s2;
      change_o <= |w_acc;
    end
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed checks of the debouncer at TICK_DIV=4/STABLE_TICKS=3 and 1/1.
module tb_sw_debounce;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0, out, rise, fall;
  logic        chg;
  logic [15:0] d_sw = '0, d_out, d_rise, d_fall;
  logic        d_chg;
  int          checks = 0, failures = 0;
  int          ec, n_chg, e_out, bad, k;
  logic [15:0] rise_acc, fall_acc, prev_out;

  sw_debounce #(.WIDTH(16), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk_i(clk), .rst_i(rst_n), .sw_i(sw), .out_o(out), .rise_o(rise), .fall_o(fall), .change_o(chg));
  sw_debounce #(.WIDTH(16), .TICK_DIV(1), .STABLE_TICKS(1)) dut_d (
    .clk_i(clk), .rst_i(rst_n), .sw_i(d_sw), .out_o(d_out), .rise_o(d_rise), .fall_o(d_fall), .change_o(d_chg));

  always #5 clk = ~clk;

  // edges since reset release; the first edge after release is numbered 1
  always @(posedge clk or negedge rst_n) ec <= !rst_n ? 0 : ec + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // edge at which a change landing on sw just after edge kk is accepted (ticks on ec%4==0)
  function automatic int exp_edge(input int kk);
    int n = 0;
    for (int e = kk + 3; e < kk + 40; e++)
      if (e % 4 == 0) begin
        n++;
        if (n == 3) return e;
      end
    return -1;
  endfunction

  task automatic clr();
    n_chg = 0; e_out = -1; rise_acc = '0; fall_acc = '0; prev_out = out;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (chg) n_chg++;
      rise_acc |= rise;
      fall_acc |= fall;
      if (out != prev_out && e_out < 0) e_out = ec;
      if ((rise | fall) != (out ^ prev_out) || chg != |(rise | fall) || (rise & ~out) != 0) bad++;
      prev_out = out;
    end
  endtask

  initial begin
    bad = 0;
    sw = 16'hFFFF;
    clr();
    step(5);
    chk("rst_out", out, 0);
    chk("rst_pulse", rise_acc | fall_acc, 0);
    chk("rst_chg", n_chg, 0);
    rst_n = 1'b1;
    clr();
    step(11);
    chk("rel_hold11", out, 0);
    step(5);
    chk("rel_edge", e_out, 12);
    chk("rel_out", out, 16'hFFFF);
    chk("rel_rise", rise_acc, 16'hFFFF);
    sw = 16'h0000;
    step(20);
    chk("clear_out", out, 0);
    // clean press / release on bit 0
    sw = 16'h0001; k = ec; clr();
    step(20);
    chk("press_edge", e_out, exp_edge(k));
    chk("press_lat", (e_out - k >= 11) && (e_out - k <= 14), 1);
    chk("press_out", out, 16'h0001);
    chk("press_rise", rise_acc, 16'h0001);
    chk("press_fall", fall_acc, 0);
    chk("press_chg", n_chg, 1);
    sw = 16'h0000; k = ec; clr();
    step(20);
    chk("rel0_edge", e_out, exp_edge(k));
    chk("rel0_out", out, 0);
    chk("rel0_fall", fall_acc, 16'h0001);
    chk("rel0_chg", n_chg, 1);
    // bounce on bit 3: 5-cycle pulses never span three ticks
    clr();
    for (int i = 0; i < 8; i++) begin
      sw[3] = ~sw[3];
      step(5);
    end
    chk("bnc_out", out, 0);
    chk("bnc_chg", n_chg, 0);
    sw[3] = 1'b1; k = ec; clr();
    step(20);
    chk("bnc_edge", e_out, exp_edge(k));
    chk("bnc_rise", rise_acc, 16'h0008);
    chk("bnc_chg1", n_chg, 1);
    sw = 16'h0000;
    step(20);
    chk("bnc_clear", out, 0);
    // multi-bit step
    sw = 16'hA5A5; k = ec; clr();
    step(20);
    chk("multi_edge", e_out, exp_edge(k));
    chk("multi_out", out, 16'hA5A5);
    chk("multi_rise", rise_acc, 16'hA5A5);
    chk("multi_chg", n_chg, 1);
    sw = 16'h0000;
    step(20);
    chk("multi_clear", out, 0);
    // reset eight cycles into a count on bit 7
    sw = 16'h0080;
    step(8);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    clr();
    step(11);
    chk("mid_hold11", out, 0);
    chk("mid_chg0", n_chg, 0);
    step(5);
    chk("mid_edge", e_out, 12);
    chk("mid_rise", rise_acc, 16'h0080);
    chk("pulse_sync", bad, 0);
    // TICK_DIV=1, STABLE_TICKS=1: exactly three cycles
    d_sw[15] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("deg_out2", d_out, 0);
    @(posedge clk); #1;
    chk("deg_out3", d_out, 16'h8000);
    chk("deg_rise3", d_rise, 16'h8000);
    chk("deg_chg3", d_chg, 1);
    @(posedge clk); #1;
    chk("deg_rise4", d_rise, 0);
    chk("deg_chg4", d_chg, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Per-bit switch debouncer that sits directly upstream of the switch controller and supplies its `in_i`. It synchronises raw asynchronous board switches into `clk_i` and accepts a new level on a bit only after it has held steady for a programmable number of sample ticks. It also emits per-bit edge pulses and a summary change pulse. Contact bounce therefore never reaches the controller's change detector and never raises a spurious interrupt or error.

## Interface
- `WIDTH`, default 16: number of switch bits.
- `TICK_DIV`, default 100000: clock cycles per sample tick. Range ≥1; 1 means a tick every cycle.
- `STABLE_TICKS`, default 4: consecutive ticks a mismatched level must hold before it is accepted. Range ≥1.
- `clk_i`, input, 1: system clock, the only clock.
- `rst_i`, input, 1: reset. **Asynchronous and active-low.** It is named `rst_i`, but asserts at logic 0.
- `sw_i`, input, WIDTH: raw switch levels, asynchronous to `clk_i`.
- `out_o`, output, WIDTH: debounced levels. Feeds the switch controller `in_i`.
- `rise_o`, output, WIDTH: one-cycle pulse per bit when `out_o[n]` goes 0→1.
- `fall_o`, output, WIDTH: one-cycle pulse per bit when `out_o[n]` goes 1→0.
- `change_o`, output, 1: equals OR of all `rise_o` and `fall_o` bits. It is registered and asserts in the same cycle as those pulses.

## Operation
- **Reset** (`rst_i`=0, any time, including mid-count):
  - Both synchroniser stages, the prescaler, all bit counters, `out_o`, `rise_o`, `fall_o` and `change_o` clear to 0.
  - Outputs are 0 while reset is held and in the first cycle after release.
- **Synchroniser:** two flops per bit, `sw_i` → `s1` → `s2`. All further logic uses `s2` only.
- **Prescaler:**
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` is combinational and true when the count equals TICK_DIV-1.
  - With TICK_DIV=1, `tick` is constantly 1.
- **Per-bit counter** `cnt[n]`, width `$clog2(STABLE_TICKS+1)`, one per bit, all bits independent:
  - If `s2[n]` == `out_o[n]`: `cnt[n]` ← 0 on every cycle, whether or not a tick occurs.
  - If `s2[n]` != `out_o[n]`, `tick`=1 and `cnt[n]` == STABLE_TICKS-1:
    - `out_o[n]` ← `s2[n]`;
    - `cnt[n]` ← 0;
    - `rise_o[n]` or `fall_o[n]` ← 1 for the next cycle.
  - If `s2[n]` != `out_o[n]`, `tick`=1 and the count is below that: `cnt[n]` ← `cnt[n]`+1.
  - If `s2[n]` != `out_o[n]` and `tick`=0: hold.
- **Pulse outputs:** `rise_o`, `fall_o` and `change_o` are 0 in every cycle without an update.
- **Bounce rejection:** any return of `s2[n]` to the current `out_o[n]` level before the acceptance tick discards the partial count.
- **Simultaneous events:**
  - Several bits may flip on the same tick; each gets its own pulse, and `change_o` is a single pulse.
  - A bit cannot flip twice within fewer than STABLE_TICKS ticks.
- The counter never exceeds STABLE_TICKS-1, so no overflow or wrap case exists.

## Timing
- Synchroniser latency: 2 cycles from a `sw_i` change to `s2`.
- Acceptance needs STABLE_TICKS ticks with the bit mismatched.
- A clean step on `sw_i` appears on `out_o` after 3+(STABLE_TICKS-1)·TICK_DIV to 2+STABLE_TICKS·TICK_DIV cycles. The exact value depends on prescaler phase.
- `out_o` and the edge pulses update on the same clock edge and are all registered, with no combinational path from `sw_i` to any output.
- The tick phase is global: the first tick after reset release occurs at cycle TICK_DIV-1, counting the first post-reset cycle as 0.
- There is no handshake with the downstream block: `out_o` is a level, and the pulses are informational only.

## Test plan
Parameters for all scenarios unless stated: WIDTH=16, TICK_DIV=4, STABLE_TICKS=3.
- **Reset values.** Drive `rst_i`=0 with `sw_i`=16'hFFFF for 5 cycles.
  - Required: `out_o`=0 and all pulses 0 throughout.
  - After release, `out_o` must remain 0 for at least 11 cycles.
- **Clean press.** Step `sw_i[0]` 0→1 and hold.
  - Required: `out_o[0]`=1 within 11–14 cycles of the step.
  - Required: a single one-cycle `rise_o[0]` and `change_o` in that same cycle; `out_o[15:1]` unchanged.
  - Then release to 0: `fall_o[0]` pulses once, with the same latency bound.
- **Bounce.** Toggle `sw_i[3]` 0→1→0 every 5 cycles for 40 cycles, then hold at 1.
  - Required: no change on `out_o[3]` and no pulse during the toggling.
  - Required: exactly one `rise_o[3]`, 11–14 cycles after the final edge.
- **Multi-bit.** Step `sw_i` 16'h0000→16'hA5A5 in one cycle.
  - Required: all eight bits flip in the same cycle.
  - Required: `rise_o`=16'hA5A5 for one cycle and a single `change_o` pulse.
- **Reset mid-count.** Step `sw_i[7]`=1 and assert `rst_i`=0 for 1 cycle, 8 cycles after the step.
  - Required: `out_o[7]` stays 0 until a full fresh interval has elapsed, i.e. at least 11 cycles after release.
- **Degenerate parameters.** Set TICK_DIV=1, STABLE_TICKS=1.
  - Required: a step on `sw_i[15]` reaches `out_o[15]` exactly 3 cycles later, with a one-cycle `rise_o[15]` in that same cycle.
